// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and parameter-range limits for the modulo
//               counter and its prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Behaviour when a step hits the count boundary.
    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } count_mode_e;

    localparam int CNT_MIN_WIDTH    = 2;
    localparam int CNT_MAX_WIDTH    = 32;
    localparam int CNT_MAX_PRESCALE = 65535;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : counter_prescaler
// Description : Divides the count enable. Counts enabled cycles
//               0..PRESCALE-1 and asserts step on the enabled cycle that
//               completes an interval.
//   clk     in  sole clock
//   reset   in  synchronous active-low reset
//   en      in  count enable
//   restart in  discard the partial interval (clear or load in the parent)
//   step    out one-cycle step request
// Revision    : 1.0 - initial release
// ============================================================================
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic step
);

    // PRESCALE=1 still uses a one-bit counter that never leaves 0, so the
    // step equation is the same for every setting.
    localparam int                c_PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(PRESCALE - 1);

    generate
        if (PRESCALE < 1 || PRESCALE > CNT_MAX_PRESCALE) begin : g_bad_prescale
            $error("counter_prescaler: PRESCALE out of range 1..65535");
        end
    endgenerate

    logic [c_PS_W-1:0] r_cnt;
    logic              w_last;

    assign w_last = (r_cnt == c_PS_MAX);
    assign step   = en && w_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + c_PS_W'(1);
        end
    end

endmodule : counter_prescaler
`default_nettype wire

// File: rtl/counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_mod
// Description : Parametrised synchronous modulo counter with up/down
//               direction, parallel load with clamp, synchronous clear,
//               wrap or saturate boundary handling and an enable prescaler.
//   clk      in  sole clock
//   reset    in  synchronous active-low reset
//   en       in  count enable (through the prescaler)
//   up       in  1 = increment, 0 = decrement
//   clear    in  synchronous clear of count, prescaler, tc and ovf
//   load     in  parallel load request
//   load_val in  value to load (clamped to MODULUS-1)
//   count    out registered count
//   tc       out one-cycle pulse after a boundary step
//   ovf      out sticky boundary / clamp flag
// Revision    : 1.0 - initial release
// ============================================================================
module counter_mod
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter longint      MODULUS  = longint'(1) << WIDTH,
    parameter count_mode_e MODE     = CNT_WRAP,
    parameter int          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // One extra bit so MODULUS = 2**WIDTH never truncates in compares or
    // in the incremented value.
    localparam logic [WIDTH:0] c_MAX = (WIDTH+1)'(MODULUS - 1);

    generate
        if (WIDTH < CNT_MIN_WIDTH || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
            $error("counter_mod: WIDTH out of range 2..32");
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("counter_mod: MODULUS out of range 2..2**WIDTH");
        end
    endgenerate

    // The MSB of r_count is always 0; it exists only so that compares and
    // the next-count mux work at WIDTH+1 bits.
    logic [WIDTH:0] r_count;
    logic           r_tc;
    logic           r_ovf;

    logic           w_step;
    logic           w_restart;
    logic [WIDTH:0] w_load_ext;
    logic           w_at_max;
    logic           w_at_min;
    logic           w_boundary;
    logic [WIDTH:0] w_next;

    assign w_restart = clear | load;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .restart (w_restart),
        .step    (w_step)
    );

    assign w_load_ext = {1'b0, load_val};
    assign w_at_max   = (r_count == c_MAX);
    assign w_at_min   = (r_count == '0);
    assign w_boundary = up ? w_at_max : w_at_min;

    always_comb begin
        w_next = r_count;
        if (up) begin
            if (!w_at_max)
                w_next = r_count + (WIDTH+1)'(1);
            else if (MODE == CNT_WRAP)
                w_next = '0;
            else
                w_next = c_MAX;
        end else begin
            if (!w_at_min)
                w_next = r_count - (WIDTH+1)'(1);
            else if (MODE == CNT_WRAP)
                w_next = c_MAX;
            else
                w_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (load) begin
            r_tc <= 1'b0;
            // Out-of-range loads clamp to the top code and flag overflow.
            if (w_load_ext > c_MAX) begin
                r_count <= c_MAX;
                r_ovf   <= 1'b1;
            end else begin
                r_count <= w_load_ext;
            end
        end else if (w_step) begin
            r_count <= w_next;
            r_tc    <= w_boundary;
            if (w_boundary)
                r_ovf <= 1'b1;
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign count = r_count[WIDTH-1:0];
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule : counter_mod
`default_nettype wire

// File: tb/tb_counter_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_mod
// Description : Directed self-checking bench for counter_mod. Four
//               instances share the input stimulus:
//                 d0 : WIDTH=4, MODULUS=10, CNT_WRAP, PRESCALE=1
//                 d1 : WIDTH=8 defaults, CNT_WRAP
//                 d2 : WIDTH=8 defaults, CNT_SAT
//                 d3 : WIDTH=4, MODULUS=10, CNT_WRAP, PRESCALE=3
//               Each scenario starts from a clear or reset so the shared
//               drive does not couple the instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_mod;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset, en, up, clear, load;
    logic [7:0] lv;

    logic [3:0] c0, c3;
    logic [7:0] c1, c2;
    logic       t0, t1, t2, t3;
    logic       o0, o1, o2, o3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(CNT_WRAP), .PRESCALE(1)) d0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv[3:0]), .count(c0), .tc(t0), .ovf(o0));

    counter_mod #(.WIDTH(8), .MODE(CNT_WRAP)) d1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv), .count(c1), .tc(t1), .ovf(o1));

    counter_mod #(.WIDTH(8), .MODE(CNT_SAT)) d2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv), .count(c2), .tc(t2), .ovf(o2));

    counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(CNT_WRAP), .PRESCALE(3)) d3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(lv[3:0]), .count(c3), .tc(t3), .ovf(o3));

    // Advance one edge; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b1; lv = 8'h05;
        tick();
        tick();
        n_checks++; if ({c0, t0, o0} !== 6'b0) begin n_fail++; $display("FAIL reset_d0 got count=%0d tc=%b ovf=%b want 0 0 0", c0, t0, o0); end
        n_checks++; if ({c1, t1, o1} !== 10'b0) begin n_fail++; $display("FAIL reset_d1 got count=%0h tc=%b ovf=%b want 0 0 0", c1, t1, o1); end
        n_checks++; if ({c2, t2, o2} !== 10'b0) begin n_fail++; $display("FAIL reset_d2 got count=%0h tc=%b ovf=%b want 0 0 0", c2, t2, o2); end
        n_checks++; if ({c3, t3, o3} !== 6'b0) begin n_fail++; $display("FAIL reset_d3 got count=%0d tc=%b ovf=%b want 0 0 0", c3, t3, o3); end
    endtask

    // Count 0..9,0,1 on d0 after reset release.
    task automatic test_wrap();
        logic [3:0] exp_c;
        load = 1'b0; en = 1'b1; up = 1'b1; reset = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp_c = 4'(i % 10);
            n_checks++;
            if (c0 !== exp_c || t0 !== (i == 10) || o0 !== (i >= 10)) begin
                n_fail++;
                $display("FAIL wrap_step%0d got count=%0d tc=%b ovf=%b want %0d %b %b",
                         i, c0, t0, o0, exp_c, (i == 10), (i >= 10));
            end
        end
    endtask

    task automatic test_down_sat();
        do_clear();
        load = 1'b1; lv = 8'h00; up = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        n_checks++; if (c1 !== 8'hFF || t1 !== 1'b1 || o1 !== 1'b1) begin n_fail++; $display("FAIL down_wrap got count=%0h tc=%b ovf=%b want ff 1 1", c1, t1, o1); end
        n_checks++; if (c2 !== 8'h00 || t2 !== 1'b1 || o2 !== 1'b1) begin n_fail++; $display("FAIL down_sat1 got count=%0h tc=%b ovf=%b want 0 1 1", c2, t2, o2); end
        tick();
        n_checks++; if (c1 !== 8'hFE || t1 !== 1'b0 || o1 !== 1'b1) begin n_fail++; $display("FAIL down_wrap2 got count=%0h tc=%b ovf=%b want fe 0 1", c1, t1, o1); end
        n_checks++; if (c2 !== 8'h00 || t2 !== 1'b1 || o2 !== 1'b1) begin n_fail++; $display("FAIL down_sat2 got count=%0h tc=%b ovf=%b want 0 1 1", c2, t2, o2); end
        en = 1'b0;
        tick();
        n_checks++; if (c2 !== 8'h00 || t2 !== 1'b0 || o2 !== 1'b1) begin n_fail++; $display("FAIL sat_idle got count=%0h tc=%b ovf=%b want 0 0 1", c2, t2, o2); end
        // Up-saturation at the top code.
        load = 1'b1; lv = 8'hFE; up = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        tick();
        n_checks++; if (c2 !== 8'hFF || t2 !== 1'b1) begin n_fail++; $display("FAIL up_sat got count=%0h tc=%b want ff 1", c2, t2); end
        tick();
        n_checks++; if (c2 !== 8'hFF || t2 !== 1'b1) begin n_fail++; $display("FAIL up_sat_hold got count=%0h tc=%b want ff 1", c2, t2); end
    endtask

    task automatic test_prescaler();
        logic [6:0] pat;
        logic [3:0] exp_c [7];
        pat = 7'b1111011;      // applied LSB first: 1,1,0,1,1,1,1
        exp_c = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        do_clear();
        up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            en = pat[i];
            tick();
            n_checks++;
            if (c3 !== exp_c[i]) begin n_fail++; $display("FAIL presc_cyc%0d got count=%0d want %0d", i, c3, exp_c[i]); end
        end
        // Two enabled cycles then clear: the partial interval is discarded.
        en = 1'b1;
        tick();
        tick();
        do_clear();
        en = 1'b1;
        tick();
        tick();
        n_checks++; if (c3 !== 4'd0) begin n_fail++; $display("FAIL presc_clear2 got count=%0d want 0", c3); end
        tick();
        n_checks++; if (c3 !== 4'd1) begin n_fail++; $display("FAIL presc_clear3 got count=%0d want 1", c3); end
    endtask

    task automatic test_load();
        do_clear();
        load = 1'b1; lv = 8'd7;
        tick();
        n_checks++; if (c0 !== 4'd7 || o0 !== 1'b0) begin n_fail++; $display("FAIL load7 got count=%0d ovf=%b want 7 0", c0, o0); end
        lv = 8'd12;
        tick();
        n_checks++; if (c0 !== 4'd9 || o0 !== 1'b1) begin n_fail++; $display("FAIL load_clamp got count=%0d ovf=%b want 9 1", c0, o0); end
        do_clear();
        load = 1'b1; lv = 8'd3; en = 1'b1; up = 1'b1;
        tick();
        n_checks++; if (c0 !== 4'd3 || t0 !== 1'b0) begin n_fail++; $display("FAIL load_vs_step got count=%0d tc=%b want 3 0", c0, t0); end
        load = 1'b0;
        tick();
        n_checks++; if (c0 !== 4'd4) begin n_fail++; $display("FAIL after_load got count=%0d want 4", c0); end
    endtask

    task automatic test_priority();
        do_clear();
        load = 1'b1; lv = 8'd12;
        tick();
        clear = 1'b1; lv = 8'd7;
        tick();
        clear = 1'b0; load = 1'b0;
        n_checks++; if (c0 !== 4'd0 || o0 !== 1'b0) begin n_fail++; $display("FAIL clear_over_load got count=%0d ovf=%b want 0 0", c0, o0); end
    endtask

    task automatic test_reset_mid();
        do_clear();
        load = 1'b1; lv = 8'h00; up = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();                       // d1 wraps to 0xFF, ovf set
        en = 1'b0; load = 1'b1; lv = 8'h54;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        n_checks++; if (c1 !== 8'h55 || o1 !== 1'b1) begin n_fail++; $display("FAIL pre_reset got count=%0h ovf=%b want 55 1", c1, o1); end
        reset = 1'b0;
        tick();
        n_checks++; if (c1 !== 8'h00 || t1 !== 1'b0 || o1 !== 1'b0) begin n_fail++; $display("FAIL reset_mid got count=%0h tc=%b ovf=%b want 0 0 0", c1, t1, o1); end
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (c1 !== 8'h02 || o1 !== 1'b0) begin n_fail++; $display("FAIL resume got count=%0h ovf=%b want 2 0", c1, o1); end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; lv = 8'h00;
        #1;
        test_reset();
        test_wrap();
        test_down_sat();
        test_prescaler();
        test_load();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_counter_mod
`default_nettype wire

// File: doc/counter_mod.md
# counter_mod

Parametrised synchronous modulo counter that succeeds the fixed 8-bit up-counter. It adds configurable width and modulus, up/down direction, parallel load, synchronous clear, wrap or saturate overflow handling, an enable prescaler, and terminal-count/overflow status. Clients are the timer, sequencer and test-pattern logic that need a programmable event or position counter on a single clock domain.

## Interface
- WIDTH, 8: counter width in bits; legal range 2..32.
- MODULUS, 2**WIDTH: count range 0..MODULUS-1; legal range 2..2**WIDTH.
- MODE, CNT_WRAP: overflow behaviour, of type count_mode_e (CNT_WRAP or CNT_SAT).
- PRESCALE, 1: enabled cycles per count step; legal range 1..65535.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- en  in  1  count enable; feeds the prescaler.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on each step.
- clear  in  1  synchronous clear of count, prescaler and ovf.
- load  in  1  parallel load request.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tc  out  1  one-cycle pulse when a step hits the boundary.
- ovf  out  1  sticky flag: boundary crossed or clamped since the last clear or reset.

## Operation
- Reset values with reset=0 at a rising edge: count=0, tc=0, ovf=0, prescaler=0. Reset overrides all other inputs.
- Priority per cycle: reset > clear > load > step.
- clear: count=0, prescaler=0, tc=0, ovf=0.
- load: if load_val <= MODULUS-1, count=load_val. Otherwise count=MODULUS-1 and ovf=1. Load sets prescaler=0 and tc=0.
- Prescaler: counts en-high cycles 0..PRESCALE-1. step=1 on the cycle where the prescaler equals PRESCALE-1 and en=1; the prescaler then returns to 0. With PRESCALE=1, step=en. With en=0 the prescaler holds.
- Step, up=1:
  - If count < MODULUS-1, count+1.
  - At MODULUS-1, CNT_WRAP gives count=0; CNT_SAT holds count at MODULUS-1. In both modes tc=1 and ovf=1.
- Step, up=0:
  - If count > 0, count-1.
  - At 0, CNT_WRAP gives count=MODULUS-1; CNT_SAT holds count at 0. In both modes tc=1 and ovf=1.
- Saturated boundary: tc pulses on every step attempted while count is held there.
- Arithmetic:
  - Comparisons and the next-count value use WIDTH+1 bits internally, so MODULUS=2**WIDTH never truncates.
  - count never leaves 0..MODULUS-1.
- Non-power-of-two MODULUS: wraps to 0 or MODULUS-1 exactly, never through the unused codes.
- Parameter checks: illegal parameter values cause an elaboration-time $error.

## Timing
- All outputs are registered with no combinational path from inputs to outputs.
- Latency: an input sampled at edge N is visible on count/tc/ovf after edge N.
- tc is high for exactly the one cycle following the boundary step. Consecutive boundary steps (CNT_SAT, PRESCALE=1) keep tc high continuously.
- A direction change takes effect on the next step with no dead cycle.
- Reset or clear asserted in the middle of a prescale interval discards the partial interval; the first step comes PRESCALE enabled cycles after release.
- load and step in the same cycle: load wins, and that step is lost.

## Structure
- Package counter_pkg:
  - count_mode_e {CNT_WRAP, CNT_SAT}.
  - Parameter-range constants CNT_MIN_WIDTH=2, CNT_MAX_WIDTH=32, CNT_MAX_PRESCALE=65535.
- Sub-module counter_prescaler:
  - Parameter PRESCALE.
  - Ports clk, reset, en, restart, step.
  - restart = clear | load.
- counter_mod:
  - Instantiates counter_prescaler.
  - Holds the count register, boundary compare, next-count mux, and the tc/ovf registers.

## Test plan
- Reset and wrap: WIDTH=4, MODULUS=10, CNT_WRAP, PRESCALE=1, up=1, en=1 for 12 cycles after reset release → count 0..9,0,1; tc high exactly in the cycle count shows 0 after 9; ovf=1 from then on.
- Down-wrap and saturation:
  - WIDTH=8 defaults, load 0x00, up=0, one step → count=0xFF, tc pulse.
  - Same with CNT_SAT → count holds 0x00, tc high on each step, ovf=1.
- Prescaler: PRESCALE=3, en toggling 1,1,0,1,1,1,1 → count increments only after the 3rd and 6th enabled cycles. A clear after 2 enabled cycles delays the next increment by 3 further enabled cycles.
- Load and clamp:
  - MODULUS=10, load_val=7 → count=7, ovf=0.
  - load_val=12 → count=9, ovf=1.
  - load together with en/step in the same cycle → count equals load value.
- Priority and reset mid-run:
  - Assert clear with load=1 → count=0, ovf=0.
  - reset=0 for one edge while counting at 0x55 with ovf=1 → count=0, tc=0, ovf=0 on the next cycle; counting resumes from 0 after release.
